// File: rtl/tag_array_icache_if.sv
// Lookup, refill-allocate and flush signal bundle between the I-cache
// pipeline (master) and the tag array (slave).
interface tag_array_icache_if #(
    parameter int unsigned TAG_WIDTH = 7,
    parameter int unsigned NUM_WAY   = 2,
    parameter int unsigned WAY_DEPTH = $clog2(NUM_WAY),
    parameter int unsigned NUM_SET   = 32,
    parameter int unsigned SET_DEPTH = $clog2(NUM_SET)
);
    logic                 r_req_valid_i;
    logic                 r_req_ready_o;
    logic [SET_DEPTH-1:0] r_req_setid_i;
    logic [TAG_WIDTH-1:0] r_req_tag_i;
    logic                 r_rsp_valid_o;
    logic                 cache_hit_o;
    logic [WAY_DEPTH-1:0] wayid_o;
    logic                 w_req_valid_i;
    logic [SET_DEPTH-1:0] w_req_setid_i;
    logic [TAG_WIDTH-1:0] w_req_tag_i;
    logic [WAY_DEPTH-1:0] w_victim_wayid_o;
    logic                 flush_i;
    logic                 flush_busy_o;

    modport master (
        output r_req_valid_i, r_req_setid_i, r_req_tag_i,
        output w_req_valid_i, w_req_setid_i, w_req_tag_i, flush_i,
        input  r_req_ready_o, r_rsp_valid_o, cache_hit_o, wayid_o,
        input  w_victim_wayid_o, flush_busy_o
    );

    modport slave (
        input  r_req_valid_i, r_req_setid_i, r_req_tag_i,
        input  w_req_valid_i, w_req_setid_i, w_req_tag_i, flush_i,
        output r_req_ready_o, r_rsp_valid_o, cache_hit_o, wayid_o,
        output w_victim_wayid_o, flush_busy_o
    );
endinterface

// File: rtl/tag_array_icache.sv
// I-cache tag/valid array: registered lookup, victim selection, set-by-set flush.
// Define ICACHE_TAG_PLRU_EN for tree pseudo-LRU replacement; default is round-robin.
module tag_array_icache #(
    parameter int unsigned TAG_WIDTH = 7,
    parameter int unsigned NUM_WAY   = 2,
    parameter int unsigned WAY_DEPTH = $clog2(NUM_WAY),
    parameter int unsigned NUM_SET   = 32,
    parameter int unsigned SET_DEPTH = $clog2(NUM_SET)
) (
    input  logic                 clk,
    input  logic                 rst,
    tag_array_icache_if.slave    bus
);

`ifdef ICACHE_TAG_PLRU_EN
    localparam int unsigned REPL_W = NUM_WAY - 1;
`else
    localparam int unsigned REPL_W = WAY_DEPTH;
`endif

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [SET_DEPTH-1:0] cnt_q, cnt_d;

    logic [TAG_WIDTH-1:0] tag_q   [NUM_SET][NUM_WAY];
    logic [NUM_WAY-1:0]   valid_q [NUM_SET];
    logic [REPL_W-1:0]    repl_q  [NUM_SET];

    logic                 rsp_valid_q;
    logic                 hit_q;
    logic [WAY_DEPTH-1:0] way_q;

    logic                 idle_c;
    logic                 accept_c;
    logic                 refill_c;
    logic [NUM_WAY-1:0]   match_c;
    logic [WAY_DEPTH-1:0] hit_way_c;
    logic [NUM_WAY-1:0]   wvalid_c;
    logic                 all_valid_c;
    logic [WAY_DEPTH-1:0] inv_way_c;
    logic [WAY_DEPTH-1:0] victim_c;

`ifdef ICACHE_TAG_PLRU_EN
    // Walk the tree from the root; each node bit points toward the LRU half.
    function automatic logic [WAY_DEPTH-1:0] plru_leaf(input logic [REPL_W-1:0] bits);
        logic [NUM_WAY-1:0]   t;
        logic [WAY_DEPTH-1:0] node;
        logic [WAY_DEPTH-1:0] way;
        logic                 b;
        t    = {1'b0, bits};
        node = '0;
        way  = '0;
        for (int l = 0; l < int'(WAY_DEPTH); l++) begin
            b = t[node];
            way[WAY_DEPTH-1-l] = b;
            node = WAY_DEPTH'((32'(node) << 1) + 32'd1 + 32'(b));
        end
        return way;
    endfunction

    // Point every node on the path away from the accessed way (it becomes MRU).
    function automatic logic [REPL_W-1:0] plru_touch(input logic [REPL_W-1:0] bits,
                                                    input logic [WAY_DEPTH-1:0] way);
        logic [NUM_WAY-1:0]   t;
        logic [WAY_DEPTH-1:0] node;
        logic                 b;
        t    = {1'b0, bits};
        node = '0;
        for (int l = 0; l < int'(WAY_DEPTH); l++) begin
            b = way[WAY_DEPTH-1-l];
            t[node] = ~b;
            node = WAY_DEPTH'((32'(node) << 1) + 32'd1 + 32'(b));
        end
        return t[REPL_W-1:0];
    endfunction
`endif

    // Flush FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush FSM next state and handshake decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idle_c   = 1'b0;
        accept_c = 1'b0;
        refill_c = 1'b0;
        case (state_q)
            IDLE: begin
                idle_c   = 1'b1;
                accept_c = bus.r_req_valid_i;
                refill_c = bus.w_req_valid_i && !bus.flush_i;
                if (bus.flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = SET_DEPTH'(cnt_q + 1'b1);
                if (cnt_q == SET_DEPTH'(NUM_SET - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag compare; lowest matching way wins when duplicates exist
    always_comb begin
        match_c   = '0;
        hit_way_c = '0;
        for (int w = 0; w < int'(NUM_WAY); w++) begin
            match_c[w] = valid_q[bus.r_req_setid_i][w] &&
                         (tag_q[bus.r_req_setid_i][w] == bus.r_req_tag_i);
        end
        for (int w = int'(NUM_WAY) - 1; w >= 0; w--) begin
            if (match_c[w]) hit_way_c = WAY_DEPTH'(w);
        end
    end

    // Victim: lowest invalid way, else the replacement state's choice
    always_comb begin
        wvalid_c    = valid_q[bus.w_req_setid_i];
        all_valid_c = &wvalid_c;
        inv_way_c   = '0;
        for (int w = int'(NUM_WAY) - 1; w >= 0; w--) begin
            if (!wvalid_c[w]) inv_way_c = WAY_DEPTH'(w);
        end
`ifdef ICACHE_TAG_PLRU_EN
        victim_c = all_valid_c ? plru_leaf(repl_q[bus.w_req_setid_i]) : inv_way_c;
`else
        victim_c = all_valid_c ? repl_q[bus.w_req_setid_i] : inv_way_c;
`endif
    end

    // Valid bits, replacement state and registered lookup response
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(NUM_SET); s++) begin
                valid_q[s] <= '0;
                repl_q[s]  <= '0;
            end
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            way_q       <= '0;
        end else begin
            rsp_valid_q <= accept_c;
            hit_q       <= accept_c && (|match_c);
            way_q       <= accept_c ? hit_way_c : '0;
`ifdef ICACHE_TAG_PLRU_EN
            if (accept_c && (|match_c))
                repl_q[bus.r_req_setid_i] <= plru_touch(repl_q[bus.r_req_setid_i], hit_way_c);
`endif
            // Refill update comes after the hit update so it wins on the same set
            if (refill_c) begin
                valid_q[bus.w_req_setid_i][victim_c] <= 1'b1;
`ifdef ICACHE_TAG_PLRU_EN
                repl_q[bus.w_req_setid_i] <= plru_touch(repl_q[bus.w_req_setid_i], victim_c);
`else
                if (all_valid_c)
                    repl_q[bus.w_req_setid_i] <= REPL_W'(repl_q[bus.w_req_setid_i] + 1'b1);
`endif
            end
            if (state_q == FLUSH) begin
                valid_q[cnt_q] <= '0;
                repl_q[cnt_q]  <= '0;
            end
        end
    end

    // Tag storage needs no reset; valid bits qualify it
    always_ff @(posedge clk) begin
        if (refill_c) tag_q[bus.w_req_setid_i][victim_c] <= bus.w_req_tag_i;
    end

    assign bus.r_req_ready_o    = idle_c;
    assign bus.r_rsp_valid_o    = rsp_valid_q;
    assign bus.cache_hit_o      = hit_q;
    assign bus.wayid_o          = way_q;
    assign bus.w_victim_wayid_o = victim_c;
    assign bus.flush_busy_o     = (state_q == FLUSH);

endmodule

// File: tb/tb_tag_array_icache.sv
// Directed self-checking bench for tag_array_icache (round-robin build; PLRU
// section added when ICACHE_TAG_PLRU_EN is defined).
module tb_tag_array_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tag_array_icache_if #(.TAG_WIDTH(7), .NUM_WAY(2), .NUM_SET(32)) bus ();
    tag_array_icache #(.TAG_WIDTH(7), .NUM_WAY(2), .NUM_SET(32)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

`ifdef ICACHE_TAG_PLRU_EN
    tag_array_icache_if #(.TAG_WIDTH(7), .NUM_WAY(4), .NUM_SET(32)) pbus ();
    tag_array_icache #(.TAG_WIDTH(7), .NUM_WAY(4), .NUM_SET(32)) pdut (
        .clk(clk), .rst(rst), .bus(pbus.slave)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.r_req_valid_i = 1'b0; bus.r_req_setid_i = '0; bus.r_req_tag_i = '0;
        bus.w_req_valid_i = 1'b0; bus.w_req_setid_i = '0; bus.w_req_tag_i = '0;
        bus.flush_i = 1'b0;
    endtask

    task automatic lookup(input logic [4:0] s, input logic [6:0] t);
        bus.r_req_valid_i = 1'b1; bus.r_req_setid_i = s; bus.r_req_tag_i = t;
    endtask

    task automatic refill(input logic [4:0] s, input logic [6:0] t);
        bus.w_req_valid_i = 1'b1; bus.w_req_setid_i = s; bus.w_req_tag_i = t;
    endtask

    initial begin
        idle_inputs();
`ifdef ICACHE_TAG_PLRU_EN
        pbus.r_req_valid_i = 1'b0; pbus.r_req_setid_i = '0; pbus.r_req_tag_i = '0;
        pbus.w_req_valid_i = 1'b0; pbus.w_req_setid_i = '0; pbus.w_req_tag_i = '0;
        pbus.flush_i = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(bus.r_rsp_valid_o), 0);
        chk("rst_hit", 32'(bus.cache_hit_o), 0);
        chk("rst_way", 32'(bus.wayid_o), 0);
        chk("rst_busy", 32'(bus.flush_busy_o), 0);
        chk("rst_ready", 32'(bus.r_req_ready_o), 1);

        // Cold lookup misses
        lookup(5'd3, 7'h15); step(); idle_inputs();
        chk("cold_rsp_valid", 32'(bus.r_rsp_valid_o), 1);
        chk("cold_hit", 32'(bus.cache_hit_o), 0);
        chk("cold_way", 32'(bus.wayid_o), 0);
        step();
        chk("idle_rsp_valid", 32'(bus.r_rsp_valid_o), 0);

        // Fill set 3 through invalid ways
        refill(5'd3, 7'h15); #1;
        chk("victim_inv0", 32'(bus.w_victim_wayid_o), 0);
        step();
        refill(5'd3, 7'h2A); #1;
        chk("victim_inv1", 32'(bus.w_victim_wayid_o), 1);
        step(); idle_inputs();

        // Back-to-back hits
        lookup(5'd3, 7'h2A); step();
        chk("hit2a_valid", 32'(bus.r_rsp_valid_o), 1);
        chk("hit2a_hit", 32'(bus.cache_hit_o), 1);
        chk("hit2a_way", 32'(bus.wayid_o), 1);
        lookup(5'd3, 7'h15); step(); idle_inputs();
        chk("hit15_valid", 32'(bus.r_rsp_valid_o), 1);
        chk("hit15_hit", 32'(bus.cache_hit_o), 1);
        chk("hit15_way", 32'(bus.wayid_o), 0);

        // Full set, round-robin replacement
        refill(5'd3, 7'h07); #1;
        chk("victim_rr0", 32'(bus.w_victim_wayid_o), 0);
        step(); idle_inputs();
        lookup(5'd3, 7'h15); step(); idle_inputs();
        chk("evicted15_hit", 32'(bus.cache_hit_o), 0);
        lookup(5'd3, 7'h07); step(); idle_inputs();
        chk("hit07_hit", 32'(bus.cache_hit_o), 1);
        chk("hit07_way", 32'(bus.wayid_o), 0);
        bus.w_req_setid_i = 5'd3; #1;
        chk("victim_rr1", 32'(bus.w_victim_wayid_o), 1);

        // Same-cycle lookup and refill: no bypass
        lookup(5'd5, 7'h11); refill(5'd5, 7'h11); step(); idle_inputs();
        chk("nobypass_valid", 32'(bus.r_rsp_valid_o), 1);
        chk("nobypass_hit", 32'(bus.cache_hit_o), 0);
        lookup(5'd5, 7'h11); step(); idle_inputs();
        chk("postwrite_hit", 32'(bus.cache_hit_o), 1);
        chk("postwrite_way", 32'(bus.wayid_o), 0);

        // Flush with a lookup accepted on the entry edge and a second flush mid-way
        lookup(5'd5, 7'h11); bus.flush_i = 1'b1; step(); idle_inputs();
        chk("preflush_rsp_valid", 32'(bus.r_rsp_valid_o), 1);
        chk("preflush_hit", 32'(bus.cache_hit_o), 1);
        for (int i = 0; i < 32; i++) begin
            chk("flush_busy", 32'(bus.flush_busy_o), 1);
            chk("flush_ready", 32'(bus.r_req_ready_o), 0);
            if (i == 1) chk("flush_rsp_valid", 32'(bus.r_rsp_valid_o), 0);
            bus.flush_i = (i == 10);
            bus.r_req_valid_i = (i == 20);
            step();
        end
        idle_inputs();
        chk("flush_done_busy", 32'(bus.flush_busy_o), 0);
        chk("flush_done_ready", 32'(bus.r_req_ready_o), 1);
        chk("flush_req_ignored", 32'(bus.r_rsp_valid_o), 0);
        lookup(5'd3, 7'h07); step(); idle_inputs();
        chk("flushed07_hit", 32'(bus.cache_hit_o), 0);
        lookup(5'd3, 7'h2A); step(); idle_inputs();
        chk("flushed2a_hit", 32'(bus.cache_hit_o), 0);
        lookup(5'd5, 7'h11); step(); idle_inputs();
        chk("flushed11_hit", 32'(bus.cache_hit_o), 0);
        bus.w_req_setid_i = 5'd3; #1;
        chk("flushed_victim", 32'(bus.w_victim_wayid_o), 0);

        // Reset mid-flush clears sets the flush has not reached yet
        refill(5'd20, 7'h33); step(); idle_inputs();
        bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
        step(); step();
        chk("midflush_busy", 32'(bus.flush_busy_o), 1);
        lookup(5'd20, 7'h33);
        rst = 1'b1; step(); rst = 1'b0; idle_inputs();
        chk("rstflush_busy", 32'(bus.flush_busy_o), 0);
        chk("rstflush_rsp_valid", 32'(bus.r_rsp_valid_o), 0);
        chk("rstflush_hit", 32'(bus.cache_hit_o), 0);
        chk("rstflush_way", 32'(bus.wayid_o), 0);
        chk("rstflush_ready", 32'(bus.r_req_ready_o), 1);
        lookup(5'd20, 7'h33); step(); idle_inputs();
        chk("rstflush_lookup_hit", 32'(bus.cache_hit_o), 0);

`ifdef ICACHE_TAG_PLRU_EN
        // Fill set 0 ways 0..3, hit way 0; tree PLRU then points at way 2
        for (int w = 0; w < 4; w++) begin
            pbus.w_req_valid_i = 1'b1; pbus.w_req_setid_i = '0;
            pbus.w_req_tag_i = 7'(8'h40 + w); #1;
            chk("plru_fill_victim", 32'(pbus.w_victim_wayid_o), 32'(w));
            step();
        end
        pbus.w_req_valid_i = 1'b0;
        #1;
        chk("plru_full_victim", 32'(pbus.w_victim_wayid_o), 0);
        pbus.r_req_valid_i = 1'b1; pbus.r_req_setid_i = '0; pbus.r_req_tag_i = 7'h40;
        step(); pbus.r_req_valid_i = 1'b0;
        chk("plru_hit", 32'(pbus.cache_hit_o), 1);
        chk("plru_hit_way", 32'(pbus.wayid_o), 0);
        #1;
        chk("plru_victim_after_hit", 32'(pbus.w_victim_wayid_o), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
